// File: rtl/timer_mc_pkg.sv
// timer_mc_pkg: shared mode encodings and default sizes for the multi-channel timer
package timer_mc_pkg;
  localparam int DEF_N_CH = 4;
  localparam int DEF_CNT_W = 64;
  localparam int DEF_PRESC_W = 16;
  localparam logic [1:0] MODE_FREE = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;
endpackage

// File: rtl/timer_mc_ch.sv
// timer_mc_ch: one timer channel with counter, one-shot done, sticky irq and sample register
module timer_mc_ch
  import timer_mc_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tick,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_limit,
  input  logic             i_clr,
  input  logic             i_sample,
  input  logic             i_irq_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_done,
  output logic             o_irq
);
  logic [CNT_W-1:0] r_cnt, r_count, w_cnt;
  logic r_done, r_irq, w_adv, w_hit, w_per, w_one, w_set;
  always_comb begin
    w_adv = i_en & i_tick & ~r_done & ~i_clr;
    w_hit = r_cnt >= i_limit;
    w_per = i_mode == MODE_PERIODIC;
    w_one = i_mode == MODE_ONESHOT;
    w_set = w_adv & w_hit & (w_per | w_one);
    // reserved mode falls through to free-run increment
    w_cnt = i_clr ? '0 : !w_adv ? r_cnt : (w_per & w_hit) ? '0 :
            (w_one & w_hit) ? r_cnt : r_cnt + 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_count <= '0;
      r_done <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_cnt <= w_cnt;
      r_count <= i_sample ? r_cnt : r_count;
      r_done <= i_clr ? 1'b0 : (w_set & w_one) ? 1'b1 : r_done;
      r_irq <= w_set ? 1'b1 : i_irq_clr ? 1'b0 : r_irq;
    end
  end
  assign o_count = r_count;
  assign o_done = r_done;
  assign o_irq = r_irq;
endmodule

// File: rtl/timer_mc.sv
// timer_mc: N_CH independent timer channels sharing one programmable prescaler
module timer_mc
  import timer_mc_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PRESC_W-1:0]    i_presc,
  input  logic                  i_presc_en,
  input  logic [N_CH-1:0]       i_ch_en,
  input  logic [2*N_CH-1:0]     i_ch_mode,
  input  logic [N_CH*CNT_W-1:0] i_ch_limit,
  input  logic [N_CH-1:0]       i_ch_clr,
  input  logic [N_CH-1:0]       i_ch_sample,
  input  logic [N_CH-1:0]       i_ch_irq_clr,
  output logic [N_CH*CNT_W-1:0] o_ch_count,
  output logic [N_CH-1:0]       o_ch_done,
  output logic [N_CH-1:0]       o_ch_irq,
  output logic                  o_irq
);
  logic [PRESC_W-1:0] r_presc_cnt;
  logic w_tick;
  logic r_irq;
  assign w_tick = i_presc_en & (r_presc_cnt == i_presc);
  // a presc lowered below the running count wraps naturally via modulo increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc_cnt <= '0;
      r_irq <= 1'b0;
    end else begin
      r_presc_cnt <= !i_presc_en ? r_presc_cnt : w_tick ? '0 : r_presc_cnt + 1'b1;
      r_irq <= |o_ch_irq;
    end
  end
  assign o_irq = r_irq;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_mc_ch #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_tick   (w_tick),
      .i_en     (i_ch_en[i]),
      .i_mode   (i_ch_mode[2*i +: 2]),
      .i_limit  (i_ch_limit[CNT_W*i +: CNT_W]),
      .i_clr    (i_ch_clr[i]),
      .i_sample (i_ch_sample[i]),
      .i_irq_clr(i_ch_irq_clr[i]),
      .o_count  (o_ch_count[CNT_W*i +: CNT_W]),
      .o_done   (o_ch_done[i]),
      .o_irq    (o_ch_irq[i])
    );
  end
endmodule
